// File: rtl/adder_ring_meter_pkg.sv
// Shared types and constants for the adder ring-oscillator meter.
package adder_ring_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Cycles spent after the window closes so in-flight edges die out
    localparam int DRAIN_CYCLES = 2;

    // Flops in the ring-tap synchroniser
    localparam int SYNC_STAGES = 2;

    // Channel-select width, never narrower than one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_ring_meter_if.sv
// Control/result bus between the wrapper (master) and the meter (slave).
// With ADDER_RING_METER_CHECK_EN defined the bus also carries err_o/err_seen_o.
interface adder_ring_meter_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16
);
    localparam int CH_W = adder_ring_meter_pkg::ch_width(NUM_CH);

    logic             start_i;
    logic [CH_W-1:0]  ch_sel_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIN_W-1:0] window_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] count_o;
    logic [WIDTH-1:0] sum_o;
    logic             ovf_o;
`ifdef ADDER_RING_METER_CHECK_EN
    logic             err_o;
    logic             err_seen_o;

    modport master (
        output start_i, ch_sel_i, a_i, b_i, window_i,
        input  busy_o, done_o, count_o, sum_o, ovf_o, err_o, err_seen_o
    );
    modport slave (
        input  start_i, ch_sel_i, a_i, b_i, window_i,
        output busy_o, done_o, count_o, sum_o, ovf_o, err_o, err_seen_o
    );
`else
    modport master (
        output start_i, ch_sel_i, a_i, b_i, window_i,
        input  busy_o, done_o, count_o, sum_o, ovf_o
    );
    modport slave (
        input  start_i, ch_sel_i, a_i, b_i, window_i,
        output busy_o, done_o, count_o, sum_o, ovf_o
    );
`endif
endinterface

// File: rtl/ring_edge_counter.sv
// Synchronises one asynchronous ring tap, detects rising edges and counts
// them into a saturating counter. ovf marks an edge lost at full scale.
module ring_edge_counter
    import adder_ring_meter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             ring_async,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   edge_reg;
    logic [CNT_W-1:0]       count_reg;
    logic                   ovf_reg;
    logic                   rise;

    // Synchroniser and edge register run continuously so the pipeline is warm when counting starts
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            sync_reg <= '0;
            edge_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ring_async};
            edge_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~edge_reg;

    // Saturating edge counter; edges are only counted while enabled
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n || clr) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (en && rise) begin
            if (count_reg == '1) begin
                ovf_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign count = count_reg;
    assign ovf   = ovf_reg;

endmodule

// File: rtl/adder_ring_meter.sv
// Measurement controller: drives operands to the adder channels, enables the
// selected ring oscillator, counts its edges over a window and latches results.
// Optional macro ADDER_RING_METER_CHECK_EN adds a sum self-check (err_o, err_seen_o).
module adder_ring_meter
    import adder_ring_meter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    adder_ring_meter_if.slave       ctl,
    input  logic [NUM_CH-1:0]       ring_i,
    input  logic [NUM_CH*WIDTH-1:0] sum_i,
    output logic [WIDTH-1:0]        a_o,
    output logic [WIDTH-1:0]        b_o,
    output logic [NUM_CH-1:0]       ring_en_o
);
    localparam int CH_W   = ch_width(NUM_CH);
    localparam int SET_W  = $clog2(SETTLE + 1);
    localparam int TMR_W0 = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam int TMR_W  = (TMR_W0 > 2) ? TMR_W0 : 2;

    state_t           state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [CH_W-1:0]  ch_reg, ch_clamped;
    logic [WIDTH-1:0] a_reg, b_reg, sum_hold_reg, sum_reg;
    logic [WIN_W-1:0] window_reg;
    logic             busy_reg, done_reg, ovf_reg;
    logic [CNT_W-1:0] count_reg;
    logic             start_accept, ring_active;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_ovf;
    logic [WIDTH-1:0] sum_arr [NUM_CH];

    assign start_accept = (state_reg == ST_IDLE) && ctl.start_i;
    assign ring_active  = (state_reg == ST_ARM) || (state_reg == ST_RUN);

    // Out-of-range channel requests fall back to the last channel
    always_comb begin
        ch_clamped = ctl.ch_sel_i;
        if (int'(ctl.ch_sel_i) >= NUM_CH) begin
            ch_clamped = CH_W'(NUM_CH - 1);
        end
    end

    // Per-channel ring enable decode and sum slicing
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ring_en_o[gi] = ring_active && (ch_reg == CH_W'(gi));
        assign sum_arr[gi]   = sum_i[gi*WIDTH +: WIDTH];
    end

    // State and phase-timer register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_reg <= ST_IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    // Next-state logic; the timer counts down the length of each timed phase
    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ctl.start_i) begin
                    state_next = ST_ARM;
                    timer_next = TMR_W'(SETTLE - 1);
                end
            end
            ST_ARM: begin
                if (timer_reg == '0) begin
                    if (window_reg == '0) begin
                        state_next = ST_DRAIN;
                        timer_next = TMR_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_next = ST_RUN;
                        timer_next = TMR_W'(window_reg) - TMR_W'(1);
                    end
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_RUN: begin
                if (timer_reg == '0) begin
                    state_next = ST_DRAIN;
                    timer_next = TMR_W'(DRAIN_CYCLES - 1);
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (timer_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    timer_next = timer_reg - TMR_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request capture, result latching and handshake outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            ch_reg       <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            window_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            count_reg    <= '0;
            ovf_reg      <= 1'b0;
            sum_hold_reg <= '0;
            sum_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start_accept) begin
                ch_reg     <= ch_clamped;
                a_reg      <= ctl.a_i;
                b_reg      <= ctl.b_i;
                window_reg <= ctl.window_i;
                busy_reg   <= 1'b1;
            end
            // Sum is taken on the last drain cycle, long after operands settled
            if (state_reg == ST_DRAIN && timer_reg == '0) begin
                sum_hold_reg <= sum_arr[ch_reg];
            end
            if (state_reg == ST_DONE) begin
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
                count_reg <= cnt_value;
                ovf_reg   <= cnt_ovf;
                sum_reg   <= sum_hold_reg;
            end
        end
    end

    ring_edge_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n   (wb_rst_n),
        .ring_async (ring_i[ch_reg]),
        .en         (state_reg == ST_RUN),
        .clr        (start_accept),
        .count      (cnt_value),
        .ovf        (cnt_ovf)
    );

`ifdef ADDER_RING_METER_CHECK_EN
    logic err_reg, err_seen_reg, sum_mismatch;

    assign sum_mismatch = (sum_hold_reg != (a_reg + b_reg));

    // Compare the measured adder against a reference sum at completion
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            err_reg      <= 1'b0;
            err_seen_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            err_reg      <= sum_mismatch;
            err_seen_reg <= err_seen_reg | sum_mismatch;
        end
    end

    assign ctl.err_o      = err_reg;
    assign ctl.err_seen_o = err_seen_reg;
`endif

    assign a_o         = a_reg;
    assign b_o         = b_reg;
    assign ctl.busy_o  = busy_reg;
    assign ctl.done_o  = done_reg;
    assign ctl.count_o = count_reg;
    assign ctl.sum_o   = sum_reg;
    assign ctl.ovf_o   = ovf_reg;

endmodule

// File: tb/tb_adder_ring_meter.sv
// Directed bench for adder_ring_meter with three channels and a 4-bit counter.
`timescale 1ns/1ps
module tb_adder_ring_meter;
    localparam int WIDTH  = 32;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;
    localparam int WIN_W  = 16;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic [NUM_CH-1:0]       ring;
    logic [NUM_CH-1:0]       ring_en;
    logic [NUM_CH*WIDTH-1:0] sum_bus;
    logic [WIDTH-1:0]        a_out, b_out;

    int               ring_half [NUM_CH] = '{default: 0};
    logic [WIDTH-1:0] sum_bias  [NUM_CH] = '{default: '0};
    int               n_checks = 0;
    int               n_pass   = 0;

    adder_ring_meter_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    adder_ring_meter #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .ctl       (bus),
        .ring_i    (ring),
        .sum_i     (sum_bus),
        .a_o       (a_out),
        .b_o       (b_out),
        .ring_en_o (ring_en)
    );

    // Adder channel model: each channel adds the driven operands plus a fault bias
    always_comb begin
        sum_bus = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_bus[c*WIDTH +: WIDTH] = a_out + b_out + sum_bias[c];
        end
    end

    // Ring oscillator model: channel c toggles every ring_half[c] clocks (0 = held low)
    initial begin
        int cnt [NUM_CH];
        ring = '0;
        for (int c = 0; c < NUM_CH; c++) cnt[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (ring_half[c] == 0) begin
                    ring[c] = 1'b0;
                end else begin
                    cnt[c]++;
                    if (cnt[c] >= ring_half[c]) begin
                        ring[c] = ~ring[c];
                        cnt[c]  = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic start_run(input logic [1:0] ch, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIN_W-1:0] win);
        @(negedge clk);
        bus.ch_sel_i = ch;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.window_i = win;
        bus.start_i  = 1'b1;
    endtask

    // lat = cycles from the cycle start_i was presented to the cycle done_o is high
    task automatic wait_done(input bit hold_start, output int lat, output logic [NUM_CH-1:0] en_arm,
                             output logic busy_first, output logic [NUM_CH-1:0] en_run);
        lat = 0; en_arm = '0; busy_first = 1'b0; en_run = '0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                busy_first = bus.busy_o;
                en_arm     = ring_en;
                if (!hold_start) bus.start_i = 1'b0;
            end
            if (lat == SETTLE + 1) en_run = ring_en;
            if (bus.done_o) break;
            if (lat >= 400) begin
                n_checks++;
                $display("FAIL wait_done: no done_o after %0d cycles, required within 400", lat);
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [NUM_CH-1:0] en_a, en_r;
        logic bsy;
        logic done_seen;

        rst_n = 1'b0;
        bus.start_i = 1'b0; bus.ch_sel_i = '0; bus.a_i = '0; bus.b_i = '0; bus.window_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_o", a_out, 0);
        chk("rst_b_o", b_out, 0);
        chk("rst_ring_en", ring_en, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_sum", bus.sum_o, 0);
        chk("rst_ovf", bus.ovf_o, 0);
`ifdef ADDER_RING_METER_CHECK_EN
        chk("rst_err", bus.err_o, 0);
        chk("rst_err_seen", bus.err_seen_o, 0);
`endif
        rst_n = 1'b1;

        // 1: ch1, 5+7, window 10, ring edge every 4 clocks -> 2 or 3 edges
        ring_half[1] = 2;
        start_run(1, 5, 7, 10);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t1_latency", lat, 18);
        chk("t1_busy_rise", bsy, 1);
        chk("t1_en_arm", en_a, 3'b010);
        chk("t1_en_run", en_r, 3'b010);
        chk("t1_count_2or3", (bus.count_o >= 2 && bus.count_o <= 3), 1);
        chk("t1_sum", bus.sum_o, 12);
        chk("t1_ovf", bus.ovf_o, 0);
        chk("t1_busy_at_done", bus.busy_o, 0);
        chk("t1_en_at_done", ring_en, 0);
        chk("t1_a_o", a_out, 5);
        chk("t1_b_o", b_out, 7);
        @(negedge clk);
        chk("t1_done_one_cycle", bus.done_o, 0);
        $display("txn 1: ch=1 win=10 lat=%0d count=%0d sum=%0d", lat, bus.count_o, bus.sum_o);

        // 2: window 0 skips RUN entirely
        start_run(1, 3, 4, 0);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t2_latency", lat, 8);
        chk("t2_en_arm", en_a, 3'b010);
        chk("t2_en_drain", en_r, 0);
        chk("t2_count", bus.count_o, 0);
        chk("t2_ovf", bus.ovf_o, 0);
        chk("t2_sum", bus.sum_o, 7);
        $display("txn 2: ch=1 win=0 lat=%0d count=%0d", lat, bus.count_o);

        // 3: ~25 edges into a 4-bit counter saturate it
        ring_half[0] = 2;
        start_run(0, 100, 23, 100);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t3_latency", lat, 108);
        chk("t3_en_arm", en_a, 3'b001);
        chk("t3_count_sat", bus.count_o, 15);
        chk("t3_ovf", bus.ovf_o, 1);
        chk("t3_sum", bus.sum_o, 123);
        $display("txn 3: ch=0 win=100 lat=%0d count=%0d ovf=%0d", lat, bus.count_o, bus.ovf_o);

        // 4: channel 3 is clamped to channel 2 (static ring), ovf cleared by new run
        start_run(3, 1000, 234, 5);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t4_latency", lat, 13);
        chk("t4_en_clamped", en_a, 3'b100);
        chk("t4_count", bus.count_o, 0);
        chk("t4_ovf_cleared", bus.ovf_o, 0);
        chk("t4_sum", bus.sum_o, 1234);
        $display("txn 4: ch_sel=3 win=5 lat=%0d en=%b sum=%0d", lat, en_a, bus.sum_o);

        // 5: start held high; operands changed mid-run are only picked up by the next run
        start_run(1, 11, 22, 10);
        fork
            wait_done(1, lat, en_a, bsy, en_r);
            begin
                repeat (3) @(negedge clk);
                bus.a_i = 32'h99;
                bus.b_i = 32'h1;
                @(negedge clk);
                chk("t5_a_held", a_out, 11);
                chk("t5_b_held", b_out, 22);
            end
        join
        chk("t5_latency_first", lat, 18);
        chk("t5_sum_first", bus.sum_o, 33);
        chk("t5_busy_at_done", bus.busy_o, 0);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t5_latency_second", lat, 18);
        chk("t5_busy_second", bsy, 1);
        chk("t5_sum_second", bus.sum_o, 32'h9A);
        chk("t5_a_second", a_out, 32'h99);
        $display("txn 5: held start, second run lat=%0d sum=0x%0h", lat, bus.sum_o);

        // 6: reset during the third RUN cycle
        start_run(1, 2, 3, 10);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) bus.start_i = 1'b0;
        end
        chk("t6_en_before_rst", ring_en, 3'b010);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_en_after_rst", ring_en, 0);
        chk("t6_busy_after_rst", bus.busy_o, 0);
        chk("t6_count_after_rst", bus.count_o, 0);
        chk("t6_sum_after_rst", bus.sum_o, 0);
        chk("t6_a_after_rst", a_out, 0);
        done_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            done_seen = done_seen | bus.done_o;
        end
        chk("t6_no_done", done_seen, 0);
        $display("txn 6: reset mid-run, done_seen=%0d", done_seen);

        // 7: faulty adder on channel 2 wraps to 1 instead of 0
        sum_bias[2] = 1;
        start_run(2, 32'hFFFF_FFFF, 1, 3);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t7_latency", lat, 11);
        chk("t7_sum_faulty", bus.sum_o, 1);
`ifdef ADDER_RING_METER_CHECK_EN
        chk("t7_err", bus.err_o, 1);
        chk("t7_err_seen", bus.err_seen_o, 1);
`endif
        $display("txn 7: faulty ch=2 sum=0x%0h", bus.sum_o);
        sum_bias[2] = 0;
        start_run(2, 5, 6, 3);
        wait_done(0, lat, en_a, bsy, en_r);
        chk("t8_sum", bus.sum_o, 11);
`ifdef ADDER_RING_METER_CHECK_EN
        chk("t8_err_clear", bus.err_o, 0);
        chk("t8_err_seen_sticky", bus.err_seen_o, 1);
`endif
        $display("txn 8: good ch=2 sum=%0d", bus.sum_o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
